// File: rtl/rf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rf_pkg : shared RF sample-path constants and capture FSM encoding  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package rf_pkg;

    localparam int RF_DATA_W      = 16;
    localparam int RF_FRAME_DEPTH = 24100;
    localparam int RF_ADDR_W      = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_e;

endpackage
`default_nettype wire

// File: rtl/rf_sample_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rf_sample_ram : simple dual-port RAM, registered read-first port   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rf_sample_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 24100,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Both updates are non-blocking, so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_capture_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rf_capture_buf : captures one frame of RF samples into RAM, with   |
// | a registered random-access read port.                  Rev 1.0     |
// +--------------------------------------------------------------------+
module rf_capture_buf
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH  = RF_FRAME_DEPTH,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   wr_count
);

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_LAST  = (ADDR_W+1)'(DEPTH - 1);

    cap_state_e        state_q, state_d;
    logic [ADDR_W:0]   wr_count_q, wr_count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_oob_q, rd_oob_d;
    logic              rd_seen_q, rd_seen_d;

    logic              wr_en;
    logic              rd_in_range;
    logic [DATA_W-1:0] ram_q;

    assign wr_en       = (state_q == ST_CAPTURE) && in_valid && !arm && (wr_count_q < C_DEPTH);
    assign rd_in_range = ({1'b0, rd_addr} < C_DEPTH);

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        busy_d     = busy_q;
        done_d     = done_q;
        overflow_d = overflow_q;
        rd_valid_d = rd_en;
        rd_oob_d   = rd_en ? !rd_in_range : rd_oob_q;
        rd_seen_d  = rd_seen_q | rd_en;

        // arm wins in every state; a sample arriving alongside it is dropped.
        if (arm) begin
            state_d    = ST_CAPTURE;
            wr_count_d = '0;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_CAPTURE: begin
                    if (wr_en) begin
                        wr_count_d = wr_count_q + 1'b1;
                        if (wr_count_q == C_LAST) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (in_valid) begin
                        overflow_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wr_count_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_oob_q   <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
            rd_oob_q   <= rd_oob_d;
            rd_seen_q  <= rd_seen_d;
        end
    end

    rf_sample_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_count_q[ADDR_W-1:0]),
        .wr_data (in_data),
        .rd_en   (rd_en && rd_in_range),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // The RAM output register carries no reset, so zero is forced until the
    // first read after reset and for out-of-range reads.
    assign rd_data  = (rd_seen_q && !rd_oob_q) ? ram_q : '0;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign wr_count = wr_count_q;

endmodule
`default_nettype wire
